// File: rtl/uart_query_pkg.sv
// Shared protocol constants, axis type and FSM state encoding for the
// accelerometer query initiator.
package uart_query_pkg;

  localparam logic [7:0] CMD_X   = 8'd120;
  localparam logic [7:0] CMD_Y   = 8'd121;
  localparam logic [7:0] CMD_Z   = 8'd122;
  localparam logic [7:0] RSP_HDR = 8'd118;

  typedef logic [1:0] axis_t;

  localparam axis_t AXIS_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT_HDR = 3'd2,
    ST_WAIT_LO  = 3'd3,
    ST_WAIT_HI  = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  function automatic logic [7:0] axis_to_cmd(input axis_t axis);
    case (axis)
      2'd0:    return CMD_X;
      2'd1:    return CMD_Y;
      default: return CMD_Z;
    endcase
  endfunction

endpackage

// File: rtl/query_timer.sv
// Clearable, enabled, saturating cycle counter; expired stays high once the
// limit is reached until the counter is cleared.
module query_timer #(
  parameter int unsigned LIMIT = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable && (count_q != LIMIT_W))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign expired = (count_q == LIMIT_W);

endmodule

// File: rtl/accel_query_initiator.sv
// Host-side initiator: sends one axis command byte to the UART transmitter and
// assembles the 3-byte reply into a 16-bit sample, with timeout reporting.
module accel_query_initiator
  import uart_query_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        CLK_50,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_axis,
  output logic        req_ready,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  input  logic        RxD_data_ready,
  input  logic [7:0]  RxD_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_axis,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy
);

  state_t      state_q, state_d;
  axis_t       axis_q, axis_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  axis_t       rsp_axis_q, rsp_axis_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        timer_clear, timer_en, expired, timeout;

  query_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (CLK_50),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  assign timer_en = (state_q != ST_IDLE) && (state_q != ST_RESP);

  // Outputs are registered, so the start pulse and response strobe are
  // decided one cycle ahead from the next state.
  always_comb begin
    state_d     = state_q;
    axis_d      = axis_q;
    lo_d        = lo_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    rsp_axis_d  = rsp_axis_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    timer_clear = 1'b0;
    timeout     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_axis == AXIS_ILLEGAL) begin
            state_d     = ST_RESP;
            rsp_axis_d  = req_axis;
            rsp_data_d  = '0;
            rsp_error_d = 1'b1;
          end else begin
            state_d     = ST_LAUNCH;
            axis_d      = req_axis;
            tx_data_d   = axis_to_cmd(req_axis);
            timer_clear = 1'b1;
            tx_start_d  = !TxD_busy;
          end
        end
      end
      ST_LAUNCH: begin
        if (expired)
          timeout = 1'b1;
        else if (tx_start_q)
          state_d = ST_WAIT_HDR;
        else
          tx_start_d = !TxD_busy;
      end
      ST_WAIT_HDR: begin
        if (RxD_data_ready) begin
          if (RxD_data == RSP_HDR)
            state_d = ST_WAIT_LO;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (RxD_data_ready) begin
          lo_d    = RxD_data;
          state_d = ST_WAIT_HI;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (RxD_data_ready) begin
          state_d     = ST_RESP;
          rsp_axis_d  = axis_q;
          rsp_data_d  = {RxD_data, lo_q};
          rsp_error_d = 1'b0;
        end else if (expired) begin
          timeout = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d     = ST_RESP;
      rsp_axis_d  = axis_q;
      rsp_data_d  = '0;
      rsp_error_d = 1'b1;
    end

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = !req_ready_d;
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      axis_q      <= '0;
      lo_q        <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_axis_q  <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      axis_q      <= axis_d;
      lo_q        <= lo_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_axis_q  <= rsp_axis_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign TxD_start = tx_start_q;
  assign TxD_data  = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_axis  = rsp_axis_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

endmodule
